// File: rtl/iob_fp_norm_seq_if.sv
// ============================================================================
// iob_fp_norm_seq_if : operand/result handshake bundle for the normaliser
// Rev 1.0
// ============================================================================
`default_nettype none

interface iob_fp_norm_seq_if #(
    parameter int DATA_W = 24,
    parameter int EXP_W  = 8
);
    logic              valid_i;
    logic              ready_o;
    logic [EXP_W-1:0]  exponent_i;
    logic [DATA_W+3:0] mantissa_i;
    logic              valid_o;
    logic              ready_i;
    logic [EXP_W-1:0]  exponent_o;
    logic [DATA_W+2:0] mantissa_o;
    logic              zero_o;
    logic              overflow_o;

    modport slave (
        input  valid_i, exponent_i, mantissa_i, ready_i,
        output ready_o, valid_o, exponent_o, mantissa_o, zero_o, overflow_o
    );

    modport master (
        output valid_i, exponent_i, mantissa_i, ready_i,
        input  ready_o, valid_o, exponent_o, mantissa_o, zero_o, overflow_o
    );
endinterface

`default_nettype wire

// File: rtl/iob_fp_norm_seq.sv
// ============================================================================
// iob_fp_norm_seq : 1-bit-per-cycle mantissa normaliser feeding the rounder
// Rev 1.0
// ============================================================================
`default_nettype none

module iob_fp_norm_seq #(
    parameter int DATA_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               cke_i,
    iob_fp_norm_seq_if.slave   bus
);
    localparam int              MW        = DATA_W + 3;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [EXP_W-1:0] e_q;
    logic [MW-1:0]    m_q;
    logic             ready_q;
    logic             valid_q;
    logic             zero_q;
    logic             ovf_q;

    logic [EXP_W-1:0] exp_inc_d;
    logic [MW-1:0]    carry_m_d;

    // Carry-out: one right shift, with R folded into S so no bit is lost.
    assign exp_inc_d = bus.exponent_i + EXP_ONE;
    assign carry_m_d = {bus.mantissa_i[DATA_W+3:2], bus.mantissa_i[1] | bus.mantissa_i[0]};

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            e_q     <= '0;
            m_q     <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (cke_i) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.valid_i) begin
                        ready_q <= 1'b0;
                        zero_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        if (bus.exponent_i == EXP_ONES) begin
                            e_q     <= bus.exponent_i;
                            m_q     <= bus.mantissa_i[MW-1:0];
                            state_q <= S_DONE;
                            valid_q <= 1'b1;
                        end else if (bus.mantissa_i == '0) begin
                            e_q     <= '0;
                            m_q     <= '0;
                            zero_q  <= 1'b1;
                            state_q <= S_DONE;
                            valid_q <= 1'b1;
                        end else if (bus.mantissa_i[DATA_W+3]) begin
                            e_q <= exp_inc_d;
                            if (exp_inc_d == EXP_ONES) begin
                                m_q     <= '0;
                                ovf_q   <= 1'b1;
                                state_q <= S_DONE;
                                valid_q <= 1'b1;
                            end else begin
                                m_q     <= carry_m_d;
                                state_q <= S_SHIFT;
                            end
                        end else begin
                            // Denormal inputs scale as exponent 1.
                            e_q     <= (bus.exponent_i == '0) ? EXP_ONE : bus.exponent_i;
                            m_q     <= bus.mantissa_i[MW-1:0];
                            state_q <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    if (m_q[MW-1]) begin
                        state_q <= S_DONE;
                        valid_q <= 1'b1;
                    end else if (e_q == EXP_ONE) begin
                        e_q     <= '0;
                        state_q <= S_DONE;
                        valid_q <= 1'b1;
                    end else begin
                        m_q <= {m_q[MW-2:0], 1'b0};
                        e_q <= e_q - EXP_ONE;
                    end
                end
                S_DONE: begin
                    if (bus.ready_i) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready_o    = ready_q;
    assign bus.valid_o    = valid_q;
    assign bus.exponent_o = e_q;
    assign bus.mantissa_o = m_q;
    assign bus.zero_o     = zero_q;
    assign bus.overflow_o = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_iob_fp_norm_seq.sv
// ============================================================================
// tb_iob_fp_norm_seq : directed + random checks against a behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_iob_fp_norm_seq;
    localparam int DW = 24;
    localparam int EW = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic cke;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic        exp_live = 1'b0;
    logic [7:0]  x_e;
    logic [26:0] x_m;
    logic        x_z;
    logic        x_o;
    int          x_lat;

    iob_fp_norm_seq_if #(.DATA_W(DW), .EXP_W(EW)) bus ();

    iob_fp_norm_seq #(.DATA_W(DW), .EXP_W(EW)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .cke_i   (cke),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Expected result from the arithmetic definition: find the leading one,
    // shift it to the hidden position unless the exponent bottoms out first.
    function automatic void model(input logic [7:0] ei, input logic [27:0] mi,
                                  output logic [7:0] eo, output logic [26:0] mo,
                                  output logic z, output logic o, output int lat);
        int e, lead, need, avail, k;
        logic [26:0] m;
        z = 1'b0; o = 1'b0;
        if (ei == 8'hFF) begin
            eo = ei; mo = mi[26:0]; lat = 0;
        end else if (mi == 28'd0) begin
            eo = 8'd0; mo = 27'd0; z = 1'b1; lat = 0;
        end else if (mi[27] && ei == 8'hFE) begin
            eo = 8'hFF; mo = 27'd0; o = 1'b1; lat = 0;
        end else begin
            if (mi[27]) begin
                m = mi[27:1];
                m[0] = mi[1] | mi[0];
                e = int'(ei) + 1;
            end else begin
                m = mi[26:0];
                e = (ei == 8'd0) ? 1 : int'(ei);
            end
            lead = 26;
            while (!m[lead]) lead--;
            need  = 26 - lead;
            avail = e - 1;
            if (need <= avail) begin
                k = need; e = e - need;
            end else begin
                k = avail; e = 0;
            end
            m   = m << k;
            eo  = 8'(e);
            mo  = m;
            lat = k + 1;
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.valid_o) begin
            if (!exp_live) begin
                check("stray_valid", 32'(bus.valid_o), 32'd0);
            end else begin
                check("exponent_o", 32'(bus.exponent_o), 32'(x_e));
                check("mantissa_o", 32'(bus.mantissa_o), 32'(x_m));
                check("zero_o",     32'(bus.zero_o),     32'(x_z));
                check("overflow_o", 32'(bus.overflow_o), 32'(x_o));
                check("ready_o_in_done", 32'(bus.ready_o), 32'd0);
            end
        end
    end

    task automatic run_op(input logic [7:0] ei, input logic [27:0] mi, input int hold, input int stall_at);
        int n = 0;
        int stalled = 0;
        logic seen = 1'b0;
        model(ei, mi, x_e, x_m, x_z, x_o, x_lat);
        @(negedge clk);
        check("ready_o_idle", 32'(bus.ready_o), 32'd1);
        bus.valid_i    = 1'b1;
        bus.exponent_i = ei;
        bus.mantissa_i = mi;
        exp_live       = 1'b1;
        @(posedge clk);
        for (int it = 0; it < 200; it++) begin
            @(negedge clk);
            bus.valid_i = 1'b0;
            if (bus.valid_o) begin
                seen = 1'b1;
                break;
            end
            if (n == stall_at && stalled < 5) begin
                cke = 1'b0;
                stalled++;
            end else begin
                cke = 1'b1;
            end
            @(posedge clk);
            if (cke) n++;
        end
        cke = 1'b1;
        check("valid_o_timeout", 32'(seen), 32'd1);
        check("latency", 32'(n), 32'(x_lat));
        repeat (hold) @(negedge clk);
        bus.ready_i = 1'b1;
        @(posedge clk);
        exp_live = 1'b0;
        @(negedge clk);
        bus.ready_i = 1'b0;
        check("valid_o_after_hs", 32'(bus.valid_o), 32'd0);
        check("ready_o_after_hs", 32'(bus.ready_o), 32'd1);
        check("exponent_held",    32'(bus.exponent_o), 32'(x_e));
        check("mantissa_held",    32'(bus.mantissa_o), 32'(x_m));
    endtask

    initial begin
        logic [7:0]  pe;
        logic [26:0] pm;
        logic        pz, po;
        int          pl;
        int          stray;

        rst_n = 1'b0; cke = 1'b1;
        bus.valid_i = 1'b0; bus.ready_i = 1'b0;
        bus.exponent_i = '0; bus.mantissa_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready_o",  32'(bus.ready_o),    32'd1);
        check("rst_valid_o",  32'(bus.valid_o),    32'd0);
        check("rst_exponent", 32'(bus.exponent_o), 32'd0);
        check("rst_mantissa", 32'(bus.mantissa_o), 32'd0);
        check("rst_zero",     32'(bus.zero_o),     32'd0);
        check("rst_overflow", 32'(bus.overflow_o), 32'd0);
        rst_n = 1'b1;

        // Hand-derived values that pin the model itself.
        model(8'd127, 28'h0000008, pe, pm, pz, po, pl);
        check("model_long_e", 32'(pe), 32'd104);
        check("model_long_m", 32'(pm), 32'h4000000);
        check("model_long_lat", 32'(pl), 32'd24);
        model(8'd127, 28'h8000003, pe, pm, pz, po, pl);
        check("model_carry_e", 32'(pe), 32'd128);
        check("model_carry_m", 32'(pm), 32'h4000001);
        model(8'd3, 28'h0000100, pe, pm, pz, po, pl);
        check("model_denorm_e", 32'(pe), 32'd0);
        check("model_denorm_m", 32'(pm), 32'h0000400);
        model(8'd254, 28'h8000000, pe, pm, pz, po, pl);
        check("model_ovf_flag", 32'(po), 32'd1);
        check("model_ovf_e", 32'(pe), 32'd255);

        run_op(8'd127, 28'h4000005, 0, -1);
        run_op(8'd127, 28'h0000008, 0, -1);
        run_op(8'd127, 28'h8000003, 0, -1);
        run_op(8'd3,   28'h0000100, 0, -1);
        run_op(8'd50,  28'h0000000, 0, -1);
        run_op(8'd254, 28'h8000000, 0, -1);
        run_op(8'd255, 28'h1234567, 2, -1);
        run_op(8'd127, 28'h0000008, 10, -1);
        run_op(8'd127, 28'h0000008, 0, 6);

        // Reset mid-SHIFT: operand discarded, nothing emerges afterwards.
        @(negedge clk);
        bus.valid_i = 1'b1; bus.exponent_i = 8'd127; bus.mantissa_i = 28'h0000008;
        @(posedge clk);
        @(negedge clk);
        bus.valid_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_ready_o", 32'(bus.ready_o), 32'd1);
        check("midrst_valid_o", 32'(bus.valid_o), 32'd0);
        check("midrst_exponent", 32'(bus.exponent_o), 32'd0);
        rst_n = 1'b1;
        stray = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.valid_o) stray++;
        end
        check("midrst_no_output", 32'(stray), 32'd0);

        for (int i = 0; i < 60; i++) begin
            logic [7:0]  re;
            logic [27:0] rm;
            case ($urandom_range(0, 9))
                0: re = 8'd0;
                1: re = 8'd1;
                2: re = 8'd254;
                3: re = 8'd255;
                default: re = 8'($urandom_range(1, 253));
            endcase
            rm = 28'($urandom) >> $urandom_range(0, 28);
            if ($urandom_range(0, 4) == 0) rm[27] = 1'b1;
            run_op(re, rm, int'($urandom_range(0, 3)),
                   ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
